// File: rtl/rc4_keystream_gen.sv
// RC4 keystream source: owns the 256x8 S-box, runs KSA on request,
// then emits one PRGA keystream byte per genVal_i request.
//
// Ports:
//   clk             : system clock, rising edge
//   n_rst_i         : async active-low reset
//   genStateArr_i   : pulse, latch key_i/key_len_i and run KSA
//   key_i           : key, byte n at [8n+7:8n]
//   key_len_i       : key length in bytes (clamped to 1..MAX_KEY_BYTES)
//   genVal_i        : pulse, produce next keystream byte
//   sarrGenerated_o : pulse, KSA complete
//   valReady_o      : pulse, keystream_o holds a new byte
//   keystream_o     : current keystream byte, held
//   busy_o          : high in INIT, KSA and PRGA states
module rc4_keystream_gen #(
  parameter int MAX_KEY_BYTES = 16
) (
  input  logic                       clk,
  input  logic                       n_rst_i,
  input  logic                       genStateArr_i,
  input  logic [8*MAX_KEY_BYTES-1:0] key_i,
  input  logic [4:0]                 key_len_i,
  input  logic                       genVal_i,
  output logic                       sarrGenerated_o,
  output logic                       valReady_o,
  output logic [7:0]                 keystream_o,
  output logic                       busy_o
);

  localparam int KBW =
    (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KSA,
    DONE,
    READY,
    PRGA_1,
    PRGA_2,
    PRGA_3
  } state_t;

  state_t state_q, state_d;

  logic [7:0]     s_q [256];
  logic [7:0]     key_q [MAX_KEY_BYTES];
  logic [KBW-1:0] lm1_q;
  logic [KBW-1:0] kb_q;
  logic [7:0]     i_q, j_q;
  logic [7:0]     ks_q;

  logic [4:0]     len_c;
  logic [KBW-1:0] lm1_c;
  logic           key_load;
  logic [7:0]     kbyte;
  logic [7:0]     si, sj;
  logic [7:0]     ksa_j, s_kj;
  logic [7:0]     p1_i, p1_j;
  logic [7:0]     t_idx, ks_c;

  always_comb begin
    len_c = key_len_i;
    if (key_len_i == 5'd0)
      len_c = 5'd1;
    else if (key_len_i > 5'(MAX_KEY_BYTES))
      len_c = 5'(MAX_KEY_BYTES);
  end

  assign lm1_c = KBW'(len_c - 5'd1);

  assign key_load = genStateArr_i &&
                    (state_q == IDLE ||
                     state_q == READY);

  assign kbyte = key_q[kb_q];
  assign si    = s_q[i_q];
  assign sj    = s_q[j_q];
  assign ksa_j = j_q + si + kbyte;
  assign s_kj  = s_q[ksa_j];
  assign p1_i  = i_q + 8'd1;
  assign p1_j  = j_q + s_q[p1_i];

  // Output byte is captured on the swap edge, so the
  // post-swap lookup is forwarded from the pre-swap reads.
  assign t_idx = si + sj;

  always_comb begin
    ks_c = s_q[t_idx];
    if (t_idx == i_q)
      ks_c = sj;
    else if (t_idx == j_q)
      ks_c = si;
  end

  always_ff @(posedge clk or negedge n_rst_i) begin
    if (!n_rst_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // PRGA_3 also takes genVal_i, so a held request
  // streams one byte every 3 cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (genStateArr_i)
          state_d = INIT;
      INIT:
        state_d = KSA;
      KSA:
        if (i_q == 8'hFF)
          state_d = DONE;
      DONE:
        state_d = READY;
      READY:
        if (genStateArr_i)
          state_d = INIT;
        else if (genVal_i)
          state_d = PRGA_1;
      PRGA_1:
        state_d = PRGA_2;
      PRGA_2:
        state_d = PRGA_3;
      PRGA_3:
        if (genVal_i)
          state_d = PRGA_1;
        else
          state_d = READY;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst_i) begin
    if (!n_rst_i) begin
      i_q   <= 8'd0;
      j_q   <= 8'd0;
      kb_q  <= '0;
      lm1_q <= '0;
      ks_q  <= 8'd0;
      for (int k = 0; k < 256; k++)
        s_q[k] <= 8'(k);
      for (int k = 0; k < MAX_KEY_BYTES; k++)
        key_q[k] <= 8'd0;
    end else begin
      if (key_load) begin
        for (int k = 0; k < MAX_KEY_BYTES; k++)
          key_q[k] <= key_i[8*k +: 8];
        lm1_q <= lm1_c;
      end
      unique case (state_q)
        INIT: begin
          for (int k = 0; k < 256; k++)
            s_q[k] <= 8'(k);
          i_q  <= 8'd0;
          j_q  <= 8'd0;
          kb_q <= '0;
        end
        KSA: begin
          s_q[i_q]   <= s_kj;
          s_q[ksa_j] <= si;
          kb_q <= (kb_q == lm1_q) ? '0
                                  : kb_q + 1'b1;
          if (i_q == 8'hFF) begin
            i_q <= 8'd0;
            j_q <= 8'd0;
          end else begin
            i_q <= i_q + 8'd1;
            j_q <= ksa_j;
          end
        end
        PRGA_1: begin
          i_q <= p1_i;
          j_q <= p1_j;
        end
        PRGA_2: begin
          s_q[i_q] <= sj;
          s_q[j_q] <= si;
          ks_q     <= ks_c;
        end
        default: ;
      endcase
    end
  end

  assign sarrGenerated_o = (state_q == DONE);
  assign valReady_o      = (state_q == PRGA_3);
  assign keystream_o     = ks_q;
  assign busy_o          = (state_q == INIT)   ||
                           (state_q == KSA)    ||
                           (state_q == PRGA_1) ||
                           (state_q == PRGA_2) ||
                           (state_q == PRGA_3);

endmodule
